offchip_mem_arbiter: RTL
========================

Name: offchip_mem_arbiter

Overview:
- Shares the single off-chip line-memory port between the instruction-cache refill path (read-only) and the data-cache path (line refill read and dirty-line writeback).
- Serialises whole-line transactions and aligns addresses to the line.
- Arbitrates round-robin and returns data and completion to the winning requester.
- Watches each transaction with a timeout, so a hung memory cannot deadlock the core.

Parameters:
- LINE_BYTES, 16, cache line size in bytes; line data width is LINE_BYTES*8; must be a power of two.
- TIMEOUT_CYCLES, 1023, maximum cycles spent waiting for offchip_mem_ready before the transaction is aborted.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset; synchronous, active-high
- i_req  input  1  instruction refill request; held until i_done
- i_addr  input  32  instruction refill byte address
- i_rdata  output  LINE_BYTES*8  returned line; valid when i_done=1
- i_done  output  1  one-cycle completion pulse
- d_req  input  1  data request; held until d_done
- d_we  input  1  1 = line writeback, 0 = line refill
- d_addr  input  32  data byte address
- d_wdata  input  LINE_BYTES*8  writeback line
- d_rdata  output  LINE_BYTES*8  returned line; valid when d_done=1 and d_we=0
- d_done  output  1  one-cycle completion pulse
- offchip_mem_addr  output  32  line-aligned address
- offchip_mem_read_en  output  1  read strobe; level, held until ready
- offchip_mem_write_en  output  1  write strobe; level, held until ready
- offchip_mem_wdata  output  LINE_BYTES*8  write line
- offchip_mem_data  input  LINE_BYTES*8  read line; valid with ready
- offchip_mem_ready  input  1  one-cycle transaction-complete pulse
- busy  output  1  1 whenever the state is not IDLE
- timeout_err  output  1  one-cycle pulse when a transaction is aborted

Behaviour:
- Reset values (rst=1 at a clock edge): state=IDLE; last_grant=D (so I wins the first tie); all enables, done pulses, busy and timeout_err are 0; addr, wdata, i_rdata and d_rdata are 0; timeout counter is 0.
- States and transitions:
  - IDLE -> GRANT when i_req|d_req.
  - GRANT -> ISSUE unconditionally.
  - ISSUE -> DONE on offchip_mem_ready.
  - ISSUE -> DONE with timeout_err when the counter reaches TIMEOUT_CYCLES.
  - DONE -> IDLE.
- Arbitration (IDLE, combinational choice registered at the edge):
  - If only one request is present, it wins.
  - If both are present, the port not equal to last_grant wins.
  - Record the owner and update last_grant.
- GRANT:
  - Latch offchip_mem_addr = {addr[31:log2(LINE_BYTES)], zeros}.
  - Latch offchip_mem_wdata = d_wdata when the D port writes.
  - Assert read_en, or write_en for a D port with d_we=1.
  - Clear the timeout counter.
- ISSUE:
  - Enables are held and the counter increments each cycle.
  - On ready, drop the enables.
  - For a read, capture offchip_mem_data into the owner's rdata register.
- DONE: pulse the owner's done for exactly one cycle; rdata stays stable until the next capture for that port.
- Latency: req rising in IDLE -> enable asserted 2 edges later. Memory ready at edge N -> done high in cycle N+1. Back-to-back transactions incur exactly one IDLE cycle between them.
- Timeout:
  - Enables drop and timeout_err pulses together with the owner's done.
  - rdata is not updated.
  - A ready arriving in the same cycle as the timeout wins; it is a normal completion with no error.
- Requester rules:
  - Request fields are sampled only in GRANT.
  - A requester deasserting req mid-transaction does not abort it; done still pulses.
  - A request held high after done re-arbitrates in the following IDLE.
- Ready while not in ISSUE: ignored.
- Never assert read_en and write_en together.
- Reset mid-transaction: return to IDLE next edge with all enables dropped; no done pulse.

Decomposition:
- Shared package/config:
  - Line size constant (matches the cache line size define).
  - State encoding constants: IDLE=2'b00, GRANT=2'b01, ISSUE=2'b10, DONE=2'b11.
  - Port id constants I=0, D=1.
- Optional sub-module rr_arb2: a two-requester round-robin picker holding last_grant; all other logic is flat.

Test Plan:
1. I read alone
   - Stimulus: i_addr=0x0000_1234; memory returns ready 3 cycles after read_en with line 0xA5..A5.
   - Required: offchip_mem_addr=0x0000_1230; read_en high for 3 cycles; i_done pulses once; i_rdata=0xA5..A5; d_done never pulses.
2. Simultaneous I and D read from reset
   - Stimulus: both requests asserted in the same cycle.
   - Required: I is served first; D is served next after exactly one IDLE cycle; grants alternate while both stay asserted.
3. D writeback
   - Stimulus: d_we=1, d_addr=0x8000_004C, d_wdata pattern.
   - Required: write_en=1 and read_en=0; address 0x8000_0040; offchip_mem_wdata equals the pattern; d_done pulses; d_rdata unchanged.
4. Timeout
   - Stimulus: TIMEOUT_CYCLES=8; memory never readies.
   - Required: after 8 ISSUE cycles, enable drops; timeout_err and i_done pulse together; busy returns to 0.
5. Reset mid-ISSUE
   - Stimulus: rst asserted for 1 cycle during ISSUE.
   - Required: next cycle state is IDLE, enables are 0, no done pulse; a later stray ready is ignored.
6. Ready/timeout collision
   - Stimulus: ready arrives in the same cycle the counter hits the limit.
   - Required: normal completion; rdata captured; timeout_err stays 0.

Source files
------------

// File: rtl/offchip_mem_arbiter_pkg.sv
// Purpose : shared constants and types for the off-chip line-memory arbiter.
// Contents: line size default, FSM state encoding, requester port ids and a line-align helper.
// Notes   : LINE_BYTES must be a power of two for line_align to be meaningful.
package offchip_mem_arbiter_pkg;

  localparam int LINE_BYTES_DEF = 16;
  localparam int ADDR_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_ISSUE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Clear the byte-offset bits so the memory always sees a whole-line address.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a, input int lb);
    return a & ~(ADDR_W'(lb) - 32'd1);
  endfunction

endpackage

// File: rtl/offchip_mem_arbiter_if.sv
// Purpose : bundles the two cache requester ports and the off-chip memory port.
// Modports: master = requesters + memory model side; slave = arbiter side.
// Signals : i_* instruction refill, d_* data refill/writeback, offchip_mem_* line memory.
interface offchip_mem_arbiter_if
  import offchip_mem_arbiter_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF
);
  localparam int LW = LINE_BYTES * 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [LW-1:0]     i_rdata;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LW-1:0]     d_wdata;
  logic [LW-1:0]     d_rdata;
  logic              d_done;

  logic [ADDR_W-1:0] offchip_mem_addr;
  logic              offchip_mem_read_en;
  logic              offchip_mem_write_en;
  logic [LW-1:0]     offchip_mem_wdata;
  logic [LW-1:0]     offchip_mem_data;
  logic              offchip_mem_ready;

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_done,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_done,
    input  offchip_mem_addr, offchip_mem_read_en, offchip_mem_write_en, offchip_mem_wdata,
    output offchip_mem_data, offchip_mem_ready
  );

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_done,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_done,
    output offchip_mem_addr, offchip_mem_read_en, offchip_mem_write_en, offchip_mem_wdata,
    input  offchip_mem_data, offchip_mem_ready
  );

endinterface

// File: rtl/offchip_mem_arbiter_rr_arb2.sv
// Purpose : two-requester round-robin picker; remembers last_grant (reset = D so I wins first tie).
// Ports   : i_req_i/i_req_d requests, i_load commits the pick, o_win_d = 1 when D wins.
// Latency : pick is combinational; last_grant updates on the edge where i_load is high.
module offchip_mem_arbiter_rr_arb2
  import offchip_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_load,
  output logic o_win_d
);

  logic r_last;

  // D wins when alone, or on a tie when I had the previous grant.
  assign o_win_d = i_req_d & (~i_req_i | (r_last == PORT_I));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= PORT_D;
    end else if (i_load) begin
      r_last <= o_win_d;
    end
  end

endmodule

// File: rtl/offchip_mem_arbiter.sv
// Purpose : shares one off-chip line-memory port between I-refill and D-refill/writeback, with timeout.
// Ports   : clk/rst, bus (slave modport: requesters + memory), busy, timeout_err pulse.
// Latency : req -> enable after 2 edges; ready at edge N -> done in cycle N+1; one IDLE cycle between txns.
module offchip_mem_arbiter
  import offchip_mem_arbiter_pkg::*;
#(
  parameter int LINE_BYTES     = LINE_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 1023
)(
  input  logic                 clk,
  input  logic                 rst,
  offchip_mem_arbiter_if.slave bus,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int LW    = LINE_BYTES * 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last counter value seen in ISSUE before the limit is reached.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_owner;
  logic               r_rd_en;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_addr;
  logic [LW-1:0]      r_wdata;
  logic [LW-1:0]      r_i_rdata;
  logic [LW-1:0]      r_d_rdata;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_tmo;

  logic               w_any_req;
  logic               w_arb_load;
  logic               w_win_d;
  logic               w_ready;
  logic               w_tmo_hit;
  logic [ADDR_W-1:0]  w_req_addr;

  assign w_any_req  = bus.i_req | bus.d_req;
  assign w_arb_load = (r_state == ST_IDLE) && w_any_req;
  // Ready only counts in ISSUE; it beats a timeout landing on the same edge.
  assign w_ready    = (r_state == ST_ISSUE) && bus.offchip_mem_ready;
  assign w_tmo_hit  = (r_state == ST_ISSUE) && !bus.offchip_mem_ready && (r_cnt == TMO_LAST);
  assign w_req_addr = (r_owner == PORT_D) ? bus.d_addr : bus.i_addr;

  offchip_mem_arbiter_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .i_req_i (bus.i_req),
    .i_req_d (bus.d_req),
    .i_load  (w_arb_load),
    .o_win_d (w_win_d)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_GRANT;
      ST_GRANT: w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_ready || w_tmo_hit) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: owner, request capture, enables, timeout counter, returned lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= PORT_I;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_cnt     <= '0;
      r_tmo     <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) r_owner <= w_win_d;
        end
        ST_GRANT: begin
          // Request fields are sampled only here; the requester may change them afterwards.
          r_addr <= line_align(w_req_addr, LINE_BYTES);
          r_cnt  <= '0;
          if ((r_owner == PORT_D) && bus.d_we) begin
            r_wr_en <= 1'b1;
            r_wdata <= bus.d_wdata;
          end else begin
            r_rd_en <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_ready) begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            if (r_rd_en) begin
              if (r_owner == PORT_D) r_d_rdata <= bus.offchip_mem_data;
              else                   r_i_rdata <= bus.offchip_mem_data;
            end
          end else if (w_tmo_hit) begin
            // Abort: drop the strobe, leave rdata untouched, flag the error with done.
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_tmo   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy                     = (r_state != ST_IDLE);
  assign timeout_err              = r_tmo;
  assign bus.i_done               = (r_state == ST_DONE) && (r_owner == PORT_I);
  assign bus.d_done               = (r_state == ST_DONE) && (r_owner == PORT_D);
  assign bus.i_rdata              = r_i_rdata;
  assign bus.d_rdata              = r_d_rdata;
  assign bus.offchip_mem_addr     = r_addr;
  assign bus.offchip_mem_read_en  = r_rd_en;
  assign bus.offchip_mem_write_en = r_wr_en;
  assign bus.offchip_mem_wdata    = r_wdata;

endmodule
